// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin arbiter slice.
package arb_pkg;

   localparam int unsigned N_REQ = 8;
   localparam int unsigned IDX_W = 3;

   typedef enum logic {
      IDLE,
      BUSY
   } arb_state_t;

   function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [N_REQ-1:0] oh);
      logic [IDX_W-1:0] idx;
      idx = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (oh[i]) idx = idx | IDX_W'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/prio_enc8.sv
// Combinational 8-to-3 priority encoder; the lowest set bit wins.
module prio_enc8
   import arb_pkg::*;
(
   input  logic [N_REQ-1:0] req,
   output logic [IDX_W-1:0] idx,
   output logic             valid
);

   always_comb begin
      idx   = '0;
      valid = 1'b0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (req[i] && !valid) begin
            idx   = IDX_W'(i);
            valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter for eight requesters with a bounded grant hold time.
module rr_arbiter8
   import arb_pkg::*;
#(
   parameter int unsigned MAX_HOLD = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_REQ-1:0] req,
   output logic [N_REQ-1:0] grant,
   output logic [IDX_W-1:0] grant_idx,
   output logic             grant_valid
);

   localparam logic [3:0] HOLD_MAX = 4'(MAX_HOLD);

   arb_state_t       state_q, state_d;
   logic [IDX_W-1:0] ptr_q, ptr_d;
   logic [IDX_W-1:0] cur_q, cur_d;
   logic [3:0]       hold_q, hold_d;
   logic [N_REQ-1:0] grant_q, grant_d;
   logic [IDX_W-1:0] grant_idx_q;
   logic             grant_valid_q;

   logic [N_REQ-1:0] masked_req;
   logic [IDX_W-1:0] masked_idx, full_idx, winner;
   logic             masked_valid, full_valid;
   logic             new_grant;

   // ptr always holds last winner + 1, so it is also the re-arbitration start
   assign masked_req = req & (N_REQ'('1) << ptr_q);

   prio_enc8 u_enc_masked (
      .req   (masked_req),
      .idx   (masked_idx),
      .valid (masked_valid)
   );

   prio_enc8 u_enc_full (
      .req   (req),
      .idx   (full_idx),
      .valid (full_valid)
   );

   assign winner = masked_valid ? masked_idx : full_idx;

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      cur_d     = cur_q;
      hold_d    = hold_q;
      grant_d   = grant_q;
      new_grant = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (full_valid) new_grant = 1'b1;
         end
         BUSY: begin
            if (req[cur_q] && (hold_q < HOLD_MAX)) begin
               hold_d = hold_q + 4'd1;
            end else if (full_valid) begin
               new_grant = 1'b1;
            end else begin
               state_d = IDLE;
               grant_d = '0;
            end
         end
         default: begin
            state_d = IDLE;
            grant_d = '0;
         end
      endcase

      if (new_grant) begin
         state_d = BUSY;
         hold_d  = 4'd1;
         ptr_d   = winner + IDX_W'(1);
         cur_d   = winner;
         grant_d = N_REQ'(1) << winner;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         ptr_q         <= '0;
         cur_q         <= '0;
         hold_q        <= '0;
         grant_q       <= '0;
         grant_idx_q   <= '0;
         grant_valid_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         ptr_q         <= ptr_d;
         cur_q         <= cur_d;
         hold_q        <= hold_d;
         grant_q       <= grant_d;
         grant_idx_q   <= onehot_to_idx(grant_d);
         grant_valid_q <= |grant_d;
      end
   end

   assign grant       = grant_q;
   assign grant_idx   = grant_idx_q;
   assign grant_valid = grant_valid_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed self-checking bench for rr_arbiter8 with MAX_HOLD = 4.
module tb_rr_arbiter8;

   logic       clk;
   logic       rst_n;
   logic [7:0] req;
   logic [7:0] grant;
   logic [2:0] grant_idx;
   logic       grant_valid;

   int checks = 0;
   int errors = 0;

   rr_arbiter8 #(.MAX_HOLD(4)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req         (req),
      .grant       (grant),
      .grant_idx   (grant_idx),
      .grant_valid (grant_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [7:0] eg, input logic [2:0] ei);
      logic ev;
      ev = |eg;
      checks++;
      assert ({grant, grant_idx, grant_valid} === {eg, ei, ev}) else begin
         errors++;
         $error("FAIL %s: got grant=%h idx=%0d valid=%b, expected grant=%h idx=%0d valid=%b",
                tag, grant, grant_idx, grant_valid, eg, ei, ev);
      end
   endtask

   initial begin
      logic [7:0]  eg;
      int unsigned k;

      // Reset with everyone requesting
      rst_n = 1'b0;
      req   = 8'hFF;
      step();
      step();
      check("reset", 8'h00, 3'd0);

      rst_n = 1'b1;
      req   = 8'h01;
      step();
      check("first_grant", 8'h01, 3'd0);

      // Lone requester 5 is re-granted across hold expiries with no gap
      req = 8'h20;
      for (int unsigned n = 1; n <= 10; n++) begin
         step();
         check($sformatf("single%0d", n), 8'h20, 3'd5);
      end

      // Fresh reset, then full rotation with all requesting
      rst_n = 1'b0;
      req   = 8'hFF;
      #2;
      rst_n = 1'b1;
      for (int unsigned n = 1; n <= 33; n++) begin
         step();
         k  = ((n - 1) / 4) % 8;
         eg = 8'h01 << k;
         check($sformatf("rot%0d", n), eg, 3'(k));
      end

      // Early release: owner 0 drops, 2 wins, then 2 drops and 7 wins
      req = 8'h84;
      step();
      check("early_owner2", 8'h04, 3'd2);
      req = 8'h80;
      step();
      check("early_owner7", 8'h80, 3'd7);
      req = 8'h05;
      step();
      check("early_wrap0", 8'h01, 3'd0);

      // Wrap search after owner 6
      req = 8'h40;
      step();
      check("owner6", 8'h40, 3'd6);
      req = 8'h03;
      step();
      check("wrap_search", 8'h01, 3'd0);

      // All requests drop: grant clears and stays clear
      req = 8'h00;
      step();
      check("to_idle", 8'h00, 3'd0);
      step();
      check("stay_idle", 8'h00, 3'd0);

      // Reset in the middle of a grant
      req = 8'h08;
      step();
      check("owner3", 8'h08, 3'd3);
      req   = 8'h18;
      rst_n = 1'b0;
      #1;
      check("async_clear", 8'h00, 3'd0);
      #4;
      rst_n = 1'b1;
      step();
      check("restart_ptr0", 8'h08, 3'd3);

      // Owner 3 holds exactly four cycles before 4 takes over
      for (int unsigned n = 2; n <= 4; n++) begin
         step();
         check($sformatf("hold3_%0d", n), 8'h08, 3'd3);
      end
      step();
      check("handover4", 8'h10, 3'd4);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
